// File: rtl/branch_resolve_unit.sv
// Pairs fetch-time branch predictions with EX resolutions; flags mispredicts, redirects fetch, trains predictor.
// Latency: all result outputs registered, valid one cycle after i_res_valid.
// Backpressure: o_pred_ready drops when the in-flight queue is full; pushes while full are dropped.
module branch_resolve_unit #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_pred_valid,
  input  logic [31:0]      i_pred_pc,
  input  logic             i_pred_taken,
  input  logic [31:0]      i_pred_target,
  output logic             o_pred_ready,
  input  logic             i_res_valid,
  input  logic             i_res_is_branch,
  input  logic             i_res_is_jump,
  input  logic             i_res_taken,
  input  logic [31:0]      i_res_target,
  output logic             o_flush,
  output logic [31:0]      o_redirect_pc,
  output logic             o_valid_update,
  output logic [31:0]      o_update_pc,
  output logic             o_actual_taken,
  output logic [31:0]      o_actual_target,
  output logic             o_is_branch,
  output logic             o_is_jump,
  output logic             o_err_underflow,
  output logic [CNT_W-1:0] o_branch_cnt,
  output logic [CNT_W-1:0] o_mispred_cnt
);

  localparam int AW = $clog2(DEPTH);

  // Prediction storage, indexed by the low pointer bits
  logic [31:0]      pc_q  [DEPTH];
  logic [31:0]      tgt_q [DEPTH];
  logic [DEPTH-1:0] taken_q;

  // Pointers carry one extra wrap bit to tell full from empty
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;

  logic             flush_q, flush_d;
  logic [31:0]      redirect_q, redirect_d;
  logic             upd_q, upd_d;
  logic [31:0]      upd_pc_q, upd_pc_d;
  logic             act_taken_q, act_taken_d;
  logic [31:0]      act_tgt_q, act_tgt_d;
  logic             is_br_q, is_br_d;
  logic             is_jmp_q, is_jmp_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;

  logic        empty, full, push, pop, underflow, mispred, push_en;
  logic [31:0] head_pc, head_tgt;
  logic        head_taken;

  assign empty      = (wr_ptr_q == rd_ptr_q);
  assign full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_pc    = pc_q[rd_ptr_q[AW-1:0]];
  assign head_tgt   = tgt_q[rd_ptr_q[AW-1:0]];
  assign head_taken = taken_q[rd_ptr_q[AW-1:0]];
  assign push       = i_pred_valid && !full;
  assign pop        = i_res_valid && !empty;
  assign underflow  = i_res_valid && empty;
  assign mispred    = (head_taken != i_res_taken) || (i_res_taken && (head_tgt != i_res_target));
  // A mispredict wipes the queue, so a same-cycle push is wrong-path and is discarded
  assign push_en    = push && !(pop && mispred);

  // Next-state for pointers, result registers, sticky error and statistics
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    flush_d     = 1'b0;
    redirect_d  = redirect_q;
    upd_d       = 1'b0;
    upd_pc_d    = upd_pc_q;
    act_taken_d = act_taken_q;
    act_tgt_d   = act_tgt_q;
    is_br_d     = is_br_q;
    is_jmp_d    = is_jmp_q;
    err_d       = err_q;
    br_cnt_d    = br_cnt_q;
    mis_cnt_d   = mis_cnt_q;

    if (push_en) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end

    if (pop) begin
      upd_d       = 1'b1;
      upd_pc_d    = head_pc;
      act_taken_d = i_res_taken;
      act_tgt_d   = i_res_target;
      // Neither flag set is handled as a conditional branch
      is_br_d     = i_res_is_branch || !i_res_is_jump;
      is_jmp_d    = i_res_is_jump;
      if (br_cnt_q != '1) begin
        br_cnt_d = br_cnt_q + 1'b1;
      end
      if (mispred) begin
        flush_d    = 1'b1;
        redirect_d = i_res_taken ? i_res_target : (head_pc + 32'd4);
        rd_ptr_d   = wr_ptr_q;
        if (mis_cnt_q != '1) begin
          mis_cnt_d = mis_cnt_q + 1'b1;
        end
      end else begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
    end else if (underflow) begin
      flush_d    = 1'b1;
      redirect_d = i_res_taken ? i_res_target : 32'd0;
      err_d      = 1'b1;
    end
  end

  // Control and result state, returned to idle on reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      flush_q     <= 1'b0;
      redirect_q  <= '0;
      upd_q       <= 1'b0;
      upd_pc_q    <= '0;
      act_taken_q <= 1'b0;
      act_tgt_q   <= '0;
      is_br_q     <= 1'b0;
      is_jmp_q    <= 1'b0;
      err_q       <= 1'b0;
      br_cnt_q    <= '0;
      mis_cnt_q   <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      flush_q     <= flush_d;
      redirect_q  <= redirect_d;
      upd_q       <= upd_d;
      upd_pc_q    <= upd_pc_d;
      act_taken_q <= act_taken_d;
      act_tgt_q   <= act_tgt_d;
      is_br_q     <= is_br_d;
      is_jmp_q    <= is_jmp_d;
      err_q       <= err_d;
      br_cnt_q    <= br_cnt_d;
      mis_cnt_q   <= mis_cnt_d;
    end
  end

  // Payload write; contents are only read behind valid pointers so no reset needed
  always_ff @(posedge i_clk) begin
    if (push_en && !i_rst) begin
      pc_q[wr_ptr_q[AW-1:0]]    <= i_pred_pc;
      tgt_q[wr_ptr_q[AW-1:0]]   <= i_pred_target;
      taken_q[wr_ptr_q[AW-1:0]] <= i_pred_taken;
    end
  end

  assign o_pred_ready    = !full;
  assign o_flush         = flush_q;
  assign o_redirect_pc   = redirect_q;
  assign o_valid_update  = upd_q;
  assign o_update_pc     = upd_pc_q;
  assign o_actual_taken  = act_taken_q;
  assign o_actual_target = act_tgt_q;
  assign o_is_branch     = is_br_q;
  assign o_is_jump       = is_jmp_q;
  assign o_err_underflow = err_q;
  assign o_branch_cnt    = br_cnt_q;
  assign o_mispred_cnt   = mis_cnt_q;

endmodule
